xmpl_cic_interp: RTL and testbench

XMPL_CIC_INTERP -- requirements
Module: xmpl_cic_interp

---
 rtl/xmpl_cic_interp.sv | 108 ++++++++++
 tb/tb_xmpl_cic_interp.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xmpl_cic_interp.sv
// xmpl_cic_interp: N-stage CIC interpolator by R with differential delay 1.
// Combs run at the input rate, a zero-stuffer raises the rate by R and
// N integrators run at the output rate. All arithmetic is OUT_W-bit
// two's complement with natural wrap-around.
module xmpl_cic_interp #(
  parameter int IN_W  = 12,
  parameter int N     = 3,
  parameter int R     = 8,
  parameter int OUT_W = IN_W + (N - 1) * $clog2(R)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    xmpl_cic_int_valid_i,
  input  logic signed [IN_W-1:0]  xmpl_cic_int_data_i,
  output logic                    xmpl_cic_int_ready_o,
  output logic                    xmpl_cic_int_valid_o,
  output logic signed [OUT_W-1:0] xmpl_cic_int_data_o,
  input  logic                    xmpl_cic_int_ready_i,
  output logic [$clog2(R)-1:0]    xmpl_cic_int_phase_o
);

  localparam int PH_W = $clog2(R);

  // Sign-extend an input sample to the internal accumulator width.
  function automatic logic signed [OUT_W-1:0] sext_in(input logic signed [IN_W-1:0] x);
    return OUT_W'(x);
  endfunction

  logic [PH_W-1:0]         phase_p1;
  logic                    vld_p1;
  logic                    out_free;
  logic                    adv;
  logic                    accept;
  logic signed [OUT_W-1:0] comb_dly_p0 [N];
  logic signed [OUT_W-1:0] comb_tap_p0 [N];
  logic signed [OUT_W-1:0] comb_out_p0;
  logic signed [OUT_W-1:0] stuff_p0;
  logic signed [OUT_W-1:0] integ_p1 [N];

  // Output slot is free when nothing is pending or downstream takes it now.
  // Phase 0 only advances with a fresh input; other phases insert zeros.
  assign out_free = !vld_p1 || xmpl_cic_int_ready_i;
  assign adv      = out_free && ((phase_p1 != '0) || xmpl_cic_int_valid_i);

  assign xmpl_cic_int_ready_o = reset_n_i && (phase_p1 == '0) && out_free;
  assign accept               = xmpl_cic_int_valid_i && xmpl_cic_int_ready_o;

  // ---- stage p0: comb chain at input rate (combinational) ----
  // Comb chain: each stage subtracts its own previous accepted input.
  always_comb begin
    logic signed [OUT_W-1:0] acc;
    comb_tap_p0 = '{default: '0};
    acc = sext_in(xmpl_cic_int_data_i);
    for (int k = 0; k < N; k++) begin
      comb_tap_p0[k] = acc;
      acc = acc - comb_dly_p0[k];
    end
    comb_out_p0 = acc;
  end

  // Zero-stuffer: comb result enters only on phase 0.
  assign stuff_p0 = (phase_p1 == '0) ? comb_out_p0 : '0;

  // Comb delay registers capture each stage input on an accepted sample.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < N; k++) comb_dly_p0[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < N; k++) comb_dly_p0[k] <= comb_tap_p0[k];
    end
  end

  // ---- stage p1: integrators at output rate ----
  // Integrator chain: each stage accumulates the previous stage's register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < N; k++) integ_p1[k] <= '0;
    end else if (adv) begin
      integ_p1[0] <= integ_p1[0] + stuff_p0;
      for (int k = 1; k < N; k++) integ_p1[k] <= integ_p1[k] + integ_p1[k-1];
    end
  end

  // Zero-stuff phase counter, wraps naturally because R is a power of two.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      phase_p1 <= '0;
    end else if (adv) begin
      phase_p1 <= phase_p1 + PH_W'(1);
    end
  end

  // Output valid: set by a new sample, dropped once consumed with nothing new.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= 1'b1;
    end else if (xmpl_cic_int_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  assign xmpl_cic_int_valid_o = vld_p1;
  assign xmpl_cic_int_data_o  = integ_p1[N-1];
  assign xmpl_cic_int_phase_o = phase_p1;

endmodule

// File: tb/tb_xmpl_cic_interp.sv
// Scoreboard bench for xmpl_cic_interp. Expected outputs come from a direct
// convolution of the zero-stuffed input history with the CIC impulse
// response, which is built by multiplying N boxcars of length R.
module tb_xmpl_cic_interp;
  localparam int IN_W  = 12;
  localparam int N     = 3;
  localparam int R     = 8;
  localparam int OUT_W = 18;
  localparam int PH_W  = 3;
  localparam int HLEN  = N * (R - 1) + 1;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    valid_i = 1'b0;
  logic signed [IN_W-1:0]  data_i = '0;
  logic                    ready_o;
  logic                    valid_o;
  logic signed [OUT_W-1:0] data_o;
  logic                    ready_i = 1'b1;
  logic [PH_W-1:0]         phase_o;

  always #5 clk = ~clk;

  xmpl_cic_interp #(.IN_W(IN_W), .N(N), .R(R)) dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .xmpl_cic_int_valid_i (valid_i),
    .xmpl_cic_int_data_i  (data_i),
    .xmpl_cic_int_ready_o (ready_o),
    .xmpl_cic_int_valid_o (valid_o),
    .xmpl_cic_int_data_o  (data_o),
    .xmpl_cic_int_ready_i (ready_i),
    .xmpl_cic_int_phase_o (phase_o)
  );

  int total = 0;
  int bad = 0;
  int h [HLEN];
  int xs [$];
  logic signed [OUT_W-1:0] expq [$];
  int npop = 0;
  int mon_phase;
  int bp_mode = 0;
  logic prev_hold = 1'b0;
  logic signed [OUT_W-1:0] prev_data;
  logic signed [OUT_W-1:0] last_data = '0;
  logic signed [OUT_W-1:0] exp_val;
  longint sum_out = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic void build_h();
    int tmp [HLEN];
    int len;
    foreach (h[i]) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int s = 0; s < N; s++) begin
      foreach (tmp[i]) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < R; j++) tmp[i+j] += h[i];
      len += R - 1;
      h = tmp;
    end
  endfunction

  // Reference: one accepted input produces R outputs; output n is the
  // convolution of h with the zero-stuffed history, delayed by N-1 registers.
  task automatic model_accept(input int x);
    int m, n, j;
    longint y;
    logic signed [OUT_W-1:0] w;
    xs.push_back(x);
    m = xs.size() - 1;
    for (int p = 0; p < R; p++) begin
      n = m * R + p;
      y = 0;
      for (int k = 0; k < HLEN; k++) begin
        j = n - (N - 1) - k;
        if (j >= 0 && (j % R) == 0) y += longint'(h[k]) * xs[j / R];
      end
      w = y[OUT_W-1:0];
      expq.push_back(w);
    end
  endtask

  // Stimulus side of the scoreboard: record accepted inputs.
  always @(negedge clk) begin
    if (reset_n && valid_i && ready_o) model_accept(int'(data_i));
  end

  // Monitor: phase bookkeeping, handshake, hold stability and data checks.
  always @(negedge clk) begin
    if (reset_n) begin
      mon_phase = (npop + (valid_o ? 1 : 0)) % R;
      chk("phase", longint'(phase_o), mon_phase);
      chk("ready_o", ready_o, ((mon_phase == 0) && (!valid_o || ready_i)) ? 1 : 0);
      if (prev_hold) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_data", data_o, prev_data);
      end
      if (valid_o && ready_i) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL data: got unexpected output %0d, required none", data_o);
        end else begin
          exp_val = expq.pop_front();
          chk("data", data_o, exp_val);
        end
        npop++;
        last_data = data_o;
        sum_out += data_o;
      end
      prev_hold = valid_o && !ready_i;
      prev_data = data_o;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Downstream ready: always high or random 50%.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready_i = (bp_mode == 0) ? 1'b1 : ($urandom_range(1, 0) == 1);
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic send(input int x);
    int c = 0;
    valid_i = 1'b1;
    data_i  = IN_W'(x);
    @(negedge clk);
    while (!ready_o && c < 200) begin
      c++;
      @(negedge clk);
    end
    if (!ready_o) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready_o=0 for %0d cycles, required 1", c);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    data_i  = '0;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int c = 0;
    valid_i = 1'b0;
    @(negedge clk);
    while ((expq.size() != 0 || valid_o) && c < 2000) begin
      c++;
      @(negedge clk);
    end
    if (expq.size() != 0 || valid_o) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d outputs pending, required 0", expq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    valid_i = 1'b0;
    data_i  = '0;
    @(posedge clk);
    #1;
    expq.delete();
    xs.delete();
    npop = 0;
    @(negedge clk);
    chk("rst_valid_o", valid_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_phase_o", longint'(phase_o), 0);
    chk("rst_ready_o", ready_o, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_o", ready_o, ready_i ? 1 : 0);
    @(posedge clk);
    #1;
  endtask

  task automatic impulse(input string nm);
    sum_out = 0;
    send(1);
    repeat (3) send(0);
    drain();
    chk(nm, sum_out, 512);
  endtask

  task automatic steady(input int x, input longint req, input string nm);
    repeat (6) send(x);
    drain();
    chk(nm, last_data, req);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

  initial begin
    int c;
    build_h();
    do_reset();

    bp_mode = 0;
    impulse("impulse_sum");

    bp_mode = 1;
    impulse("impulse_bp_sum");

    bp_mode = 0;
    steady(100, 6400, "step_settle");
    steady(-2048, -131072, "fullscale_neg");
    steady(2047, 131008, "fullscale_pos");

    // Starvation at phase 0 in the middle of a stream.
    repeat (3) send(int'($urandom_range(4095, 0)) - 2048);
    idle(R + 5);
    @(negedge clk);
    chk("starve_valid_o", valid_o, 0);
    chk("starve_phase_o", longint'(phase_o), 0);
    @(posedge clk);
    #1;
    repeat (4) send(int'($urandom_range(4095, 0)) - 2048);
    drain();

    // Random samples, random gaps, random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(4095, 0)) - 2048);
      if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
    end
    drain();

    // Reset in the middle of a burst at phase 5.
    bp_mode = 0;
    send(7);
    c = 0;
    while (phase_o != 3'd5 && c < 50) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("reach_phase5", longint'(phase_o), 5);
    do_reset();
    impulse("impulse_after_reset");

    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
